// File: rtl/msg_packer.sv
// Packs a 64-bit AXI-Stream message into 512-bit beats with byte-accurate keep, last and
// {message index, running byte count} tuser. Optional tkeep checking: define MSG_PACKER_CHECK_EN.
module msg_packer #(
  parameter int S_AXIS_DATA_WIDTH  = 64,
  parameter int M_AXIS_DATA_WIDTH  = 512,
  parameter int M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            err_sticky
);

  localparam int RATIO = M_AXIS_DATA_WIDTH / S_AXIS_DATA_WIDTH;
  localparam int SKW   = S_AXIS_DATA_WIDTH / 8;
  localparam int MKW   = M_AXIS_DATA_WIDTH / 8;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  typedef enum logic {FILL, HOLD} state_t;

  function automatic logic [63:0] popcount(input logic [SKW-1:0] k);
    logic [63:0] c;
    c = '0;
    for (int i = 0; i < SKW; i++) c = c + 64'(k[i]);
    return c;
  endfunction

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [M_AXIS_DATA_WIDTH-1:0]   acc_data_q, acc_data_d;
  logic [MKW-1:0]                 acc_keep_q, acc_keep_d;
  logic [63:0]                    byte_cnt_q, byte_cnt_d;
  logic [63:0]                    msg_idx_q, msg_idx_d;
  logic                           last_q, last_d;
  logic                           accept;

  // Ready drops combinationally with reset so no word is taken while state is being cleared.
  assign s_axis_tready = (state_q == FILL) && !axi_reset;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    byte_cnt_d = byte_cnt_q;
    msg_idx_d  = msg_idx_q;
    last_d     = last_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          acc_data_d[int'(idx_q)*S_AXIS_DATA_WIDTH +: S_AXIS_DATA_WIDTH] = s_axis_tdata;
          acc_keep_d[int'(idx_q)*SKW +: SKW] = s_axis_tkeep;
          byte_cnt_d = byte_cnt_q + popcount(s_axis_tkeep);
          if (idx_q == IDX_LAST || s_axis_tlast) begin
            state_d = HOLD;
            last_d  = s_axis_tlast;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (m_axis_tready) begin
          state_d    = FILL;
          idx_d      = '0;
          acc_data_d = '0;
          acc_keep_d = '0;
          last_d     = 1'b0;
          if (last_q) begin
            byte_cnt_d = '0;
            msg_idx_d  = msg_idx_q + 64'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q    <= FILL;
      idx_q      <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      byte_cnt_q <= '0;
      msg_idx_q  <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      byte_cnt_q <= byte_cnt_d;
      msg_idx_q  <= msg_idx_d;
      last_q     <= last_d;
    end
  end

  // The accumulator doubles as the held output beat; byte_cnt already includes the closing word.
  assign m_axis_tdata  = acc_data_q;
  assign m_axis_tkeep  = acc_keep_q;
  assign m_axis_tuser  = {msg_idx_q, byte_cnt_q};
  assign m_axis_tvalid = (state_q == HOLD);
  assign m_axis_tlast  = last_q;

`ifdef MSG_PACKER_CHECK_EN
  logic err_q, err_d;
  logic keep_bad;

  always_comb begin
    keep_bad = ((s_axis_tkeep & (s_axis_tkeep + SKW'(1))) != '0) ||
               (!s_axis_tlast && (s_axis_tkeep != '1));
    err_d    = err_q | (accept && keep_bad);
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign err_sticky = err_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_msg_packer.sv
// Randomised bench for msg_packer: an array-based packing model predicts every output beat.
module tb_msg_packer;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  s_tdata = '0;
  logic [7:0]   s_tkeep = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  logic [63:0] w_data[$];
  logic [7:0]  w_keep[$];
  logic [63:0] msg_m = '0;
  int sink_mode = 0;
  int gap_max = 0;

  msg_packer dut (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .err_sticky(err)
  );

  always #5 clk = ~clk;

  // Sink: picks tready for the coming edge, then records the beat that edge will transfer.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(negedge clk);
      case (sink_mode)
        0: m_tready = 1'b1;
        1: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
      if (!rst && m_tvalid && m_tready) got_q.push_back({m_tdata, m_tkeep, m_tuser, m_tlast});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: words fill 8 lanes in order; a beat closes on lane 7 or the message's last word.
  task automatic model_msg();
    beat_t b;
    logic [63:0] bytes;
    int lane;
    b = '0; bytes = '0; lane = 0;
    for (int i = 0; i < w_data.size(); i++) begin
      b.data[lane*64 +: 64] = w_data[i];
      b.keep[lane*8 +: 8] = w_keep[i];
      bytes = bytes + 64'($countones(w_keep[i]));
      if (lane == 7 || i == w_data.size() - 1) begin
        b.user = {msg_m, bytes};
        b.last = (i == w_data.size() - 1);
        exp_q.push_back(b);
        b = '0;
        lane = 0;
      end else begin
        lane++;
      end
    end
    msg_m = msg_m + 64'd1;
  endtask

  task automatic drive_words(input bit with_last);
    int t;
    for (int i = 0; i < w_data.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge clk);
        s_tvalid = 1'b0;
      end
      @(negedge clk);
      s_tdata  = w_data[i];
      s_tkeep  = w_keep[i];
      s_tlast  = with_last && (i == w_data.size() - 1);
      s_tvalid = 1'b1;
      t = 0;
      while (!s_tready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        n_checks++; n_errors++;
        $display("FAIL input_accept: word %0d not accepted, s_axis_tready=%b required 1", i, s_tready);
        s_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic new_case();
    exp_q.delete(); got_q.delete(); w_data.delete(); w_keep.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; sink_mode = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0) begin n_errors++; $display("FAIL rst_tvalid: got %b need 0", m_tvalid); end
    n_checks++; if (m_tlast !== 1'b0) begin n_errors++; $display("FAIL rst_tlast: got %b need 0", m_tlast); end
    n_checks++; if (m_tdata !== '0) begin n_errors++; $display("FAIL rst_tdata: got %h need 0", m_tdata); end
    n_checks++; if (m_tkeep !== '0) begin n_errors++; $display("FAIL rst_tkeep: got %h need 0", m_tkeep); end
    n_checks++; if (m_tuser !== '0) begin n_errors++; $display("FAIL rst_tuser: got %h need 0", m_tuser); end
    n_checks++; if (s_tready !== 1'b0) begin n_errors++; $display("FAIL rst_s_tready: got %b need 0", s_tready); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b need 0", err); end
    rst = 1'b0;
    #1;
    n_checks++; if (s_tready !== 1'b1) begin n_errors++; $display("FAIL post_rst_s_tready: got %b need 1", s_tready); end
    msg_m = '0;
  endtask

  task automatic test_full16();
    new_case(); sink_mode = 0; gap_max = 0;
    for (int i = 0; i < 16; i++) begin w_data.push_back(64'(i)); w_keep.push_back(8'hFF); end
    model_msg();
    drive_words(1'b1);
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL full16_count: got %0d beats need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL full16_beat%0d: got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (got_q[0].keep !== 64'hFFFF_FFFF_FFFF_FFFF || got_q[0].user !== 128'h40 || got_q[0].last !== 1'b0) begin
      n_errors++; $display("FAIL full16_first: keep %h user %h last %b need all-ones/40/0", got_q[0].keep, got_q[0].user, got_q[0].last);
    end
    n_checks++;
    if (got_q[1].user !== 128'h80 || got_q[1].last !== 1'b1) begin
      n_errors++; $display("FAIL full16_second: user %h last %b need 80/1", got_q[1].user, got_q[1].last);
    end
  endtask

  task automatic test_short();
    new_case(); sink_mode = 0; gap_max = 1;
    w_data.push_back(64'h0000_0000_00C3_B2A1); w_keep.push_back(8'h07);
    model_msg(); drive_words(1'b1);
    w_data.delete(); w_keep.delete();
    w_data.push_back({$urandom, $urandom}); w_keep.push_back(8'hFF);
    model_msg(); drive_words(1'b1);
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL short_count: got %0d beats need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL short_beat%0d: got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (got_q[0].data !== 512'hC3B2A1 || got_q[0].keep !== 64'h7 || got_q[0].user[63:0] !== 64'd3 || got_q[0].last !== 1'b1) begin
      n_errors++; $display("FAIL short_beat: data %h keep %h bytes %h last %b need C3B2A1/7/3/1", got_q[0].data, got_q[0].keep, got_q[0].user[63:0], got_q[0].last);
    end
    n_checks++;
    if (got_q[1].user[127:64] !== got_q[0].user[127:64] + 64'd1) begin
      n_errors++; $display("FAIL short_msg_idx: got %h need %h", got_q[1].user[127:64], got_q[0].user[127:64] + 64'd1);
    end
  endtask

  task automatic test_zero_len();
    new_case(); sink_mode = 2; gap_max = 0;
    w_data.push_back({$urandom, $urandom}); w_keep.push_back(8'h00);
    model_msg(); drive_words(1'b1);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tkeep !== '0 || m_tlast !== 1'b1 || m_tuser[63:0] !== 64'd0) begin
      n_errors++; $display("FAIL zero_len: valid %b keep %h last %b bytes %h need 1/0/1/0", m_tvalid, m_tkeep, m_tlast, m_tuser[63:0]);
    end
    sink_mode = 0;
    wait_drain();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_errors++; $display("FAIL zero_len_beat: got %0d beats, first %h need %h", got_q.size(), got_q[0], exp_q[0]);
    end
  endtask

  task automatic test_backpressure();
    beat_t snap;
    int t;
    new_case(); sink_mode = 2; gap_max = 0;
    for (int i = 0; i < 10; i++) begin w_data.push_back({$urandom, $urandom}); w_keep.push_back(8'hFF); end
    model_msg();
    fork drive_words(1'b1); join_none
    t = 0;
    while (!m_tvalid && t < 100) begin @(negedge clk); t++; end
    n_checks++;
    if (m_tvalid !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %b need 1", m_tvalid); end
    snap = {m_tdata, m_tkeep, m_tuser, m_tlast};
    repeat (10) begin
      @(negedge clk);
      n_checks++;
      if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== snap || m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
        n_errors++; $display("FAIL bp_stable: valid %b s_tready %b user %h need 1/0/%h", m_tvalid, s_tready, m_tuser, snap.user);
      end
    end
    sink_mode = 0;
    wait fork;
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL bp_count: got %0d beats need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL bp_beat%0d: got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    new_case(); sink_mode = 1; gap_max = 2;
    for (int m = 0; m < 12; m++) begin
      w_data.delete(); w_keep.delete();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        w_data.push_back({$urandom, $urandom});
        w_keep.push_back((i == n - 1) ? (8'hFF >> $urandom_range(0, 8)) : 8'hFF);
      end
      model_msg();
      drive_words(1'b1);
    end
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rand_count: got %0d beats need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL rand_beat%0d: got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL rand_err: got %b need 0", err); end
  endtask

  task automatic test_reset_mid();
    new_case(); sink_mode = 0; gap_max = 0;
    for (int i = 0; i < 5; i++) begin w_data.push_back({$urandom, $urandom}); w_keep.push_back(8'hFF); end
    drive_words(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    msg_m = '0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (got_q.size() != 0) begin n_errors++; $display("FAIL rstmid_no_beat: got %0d beats need 0", got_q.size()); end
    w_data.delete(); w_keep.delete();
    w_data.push_back({$urandom, $urandom}); w_keep.push_back(8'hFF);
    model_msg(); drive_words(1'b1);
    wait_drain();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0].user !== {64'd0, 64'd8}) begin
      n_errors++; $display("FAIL rstmid_beat: got %0d beats user %h need 1 beat user %h", got_q.size(), got_q[0].user, {64'd0, 64'd8});
    end
  endtask

  task automatic test_err();
    logic exp_err;
`ifdef MSG_PACKER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    new_case(); sink_mode = 0; gap_max = 0;
    w_data.push_back({$urandom, $urandom}); w_keep.push_back(8'h05);
    model_msg(); drive_words(1'b1);
    n_checks++;
    if (err !== exp_err) begin n_errors++; $display("FAIL err_set: got %b need %b", err, exp_err); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (err !== exp_err) begin n_errors++; $display("FAIL err_hold: got %b need %b", err, exp_err); end
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_errors++; $display("FAIL err_beat: got %0d beats first %h need %h", got_q.size(), got_q[0], exp_q[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    msg_m = '0;
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL err_clear: got %b need 0", err); end
  endtask

  initial begin
    test_reset();
    test_full16();
    test_short();
    test_zero_len();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/msg_packer.md
Name: msg_packer

Overview:
- Upstream transmitter for the hash engine's slave stream.
- Packs a narrow AXI-Stream message (64-bit words) into the 512-bit beats the engine consumes, with byte-accurate tkeep, tlast and tuser.
- tuser carries the running byte count and a message sequence number.
- Sits between the host/DMA word stream and the engine's s_axis port.

Parameters:
- S_AXIS_DATA_WIDTH, 64: input word width; must divide M_AXIS_DATA_WIDTH; multiple of 8.
- M_AXIS_DATA_WIDTH, 512: output beat width (one SHA-2 block).
- M_AXIS_TUSER_WIDTH, 128: output tuser width; fixed 128.

Ports:
- axi_aclk  in  1  sole clock, rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  S_AXIS_DATA_WIDTH  message word; byte 0 in bits [7:0].
- s_axis_tkeep  in  S_AXIS_DATA_WIDTH/8  valid bytes, contiguous from bit 0.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  word accepted when tvalid&&tready.
- s_axis_tlast  in  1  final word of message.
- m_axis_tdata  out  M_AXIS_DATA_WIDTH  packed beat.
- m_axis_tkeep  out  M_AXIS_DATA_WIDTH/8  valid bytes of beat.
- m_axis_tuser  out  M_AXIS_TUSER_WIDTH  [63:0] bytes so far incl. this beat; [127:64] message index.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of message.
- err_sticky  out  1  protocol error flag (see Optional Feature).

Behaviour:
- RATIO = M_AXIS_DATA_WIDTH/S_AXIS_DATA_WIDTH (8). Word index idx counts 0..RATIO-1.
- Reset values, applied on the axi_aclk edge while axi_reset=1:
  - State FILL, idx=0.
  - Accumulator data and keep cleared.
  - byte_cnt=0, msg_idx=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tuser=0.
  - s_axis_tready=0 during reset, 1 on the first cycle after.
  - err_sticky=0.
- Reset mid-operation discards any partial beat and the held beat with no output. Message counters restart at 0.
- FILL state (s_axis_tready=1, m_axis_tvalid=0):
  - An accepted word is written to lane idx: data[idx*S +: S], keep[idx*S/8 +: S/8].
  - byte_cnt += popcount(s_axis_tkeep), 64-bit, wraps mod 2^64.
  - If idx==RATIO-1 or s_axis_tlast: go to HOLD next cycle and assert m_axis_tvalid. m_axis_tlast = s_axis_tlast. m_axis_tuser = {msg_idx, updated byte_cnt}.
  - Otherwise idx++.
- Latency: beat valid on the cycle after the edge that accepted its closing word.
- HOLD state (s_axis_tready=0):
  - All m_axis outputs stable until m_axis_tready=1.
  - On transfer: go to FILL next cycle; clear accumulator data/keep to 0; idx=0.
  - If the transferred beat had tlast: byte_cnt=0 and msg_idx++ (wraps mod 2^64).
- Unused upper lanes of a short final beat read data=0, keep=0.
- Throughput: one idle input cycle per output beat (HOLD→FILL).
- Zero-length message (tlast, tkeep=0, idx=0) emits one beat with keep=0, last=1, tuser[63:0]=0.
- A tlast word with tkeep=0 at idx>0 closes the beat with no added bytes.
- m_axis_tready ignored when m_axis_tvalid=0.

Optional Feature:
- Macro: MSG_PACKER_CHECK_EN.
- Defined: on each accepted word, flag an error if:
  - tkeep is non-contiguous (not of form 0..01..1), or
  - tkeep != all-ones while tlast=0.
- On error, err_sticky sets to 1 and holds until axi_reset; the word is still packed as given.
- Undefined: no checking logic; err_sticky tied to 0.

Test Plan:
- 16 full words (0x0000..0F as 64-bit values), tlast on word 15, m_axis_tready=1:
  - Beat 1: keep=all-ones, tuser=0x0…0040, last=0.
  - Beat 2: tuser[63:0]=0x80, tuser[127:64]=0, last=1.
- 3-byte message, one word tkeep=0x07, tlast=1:
  - One beat; keep=0x…0007; data[23:0] matches; upper bits 0; tuser[63:0]=3; last=1.
  - Next message's beat shows tuser[127:64]=1.
- Backpressure: m_axis_tready held 0 for 10 cycles after beat valid:
  - Outputs stable throughout; s_axis_tready=0.
  - No input word lost; transfer completes on release.
- Zero-length message (tkeep=0, tlast=1):
  - Beat with keep=0, last=1, tuser[63:0]=0.
- axi_reset pulsed at idx=5 of a message:
  - No beat emitted.
  - Subsequent 1-word message yields tuser={0,8}.
- MSG_PACKER_CHECK_EN defined:
  - tkeep=0x05 → err_sticky=1 next cycle, stays 1 until reset.
  - Undefined: err_sticky stays 0.
